prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter RUN_CYCLES, default 28: number of clock cycles `working` is held high per program run.
REQ-002 Parameter NUM_REGS, default 8: number of registers read back after a run, indices 0..NUM_REGS-1, max 15.
REQ-003 Port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port in_valid  in  1  an input byte is present on in_data.
REQ-006 Port in_data  in  8  input byte stream carrying word count and program words.
REQ-007 Port in_ready  out  1  loader accepts a byte this cycle.
REQ-008 Port addr  out  32  instruction memory write address, drives processor addr.
REQ-009 Port wr  out  1  instruction memory write strobe, drives processor wr.
REQ-010 Port wdata  out  32  instruction word to write, drives processor wdata.
REQ-011 Port working  out  1  processor run enable.
REQ-012 Port rID  out  4  register readback select, drives processor rID.
REQ-013 Port rdata  in  32  register value returned by processor for rID.
REQ-014 Port out_valid  out  1  out_data holds a register value.
REQ-015 Port out_data  out  32  register value being reported.
REQ-016 Port out_ready  in  1  consumer accepts out_data.
REQ-017 Port done  out  1  one-cycle pulse when readback of the last register completes.

Function
REQ-018 The loader SHALL have states IDLE, LOAD, WRITE, RUN, DSEL and DOUT.
REQ-019 A byte SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and LOAD only, and 0 while reset is asserted.
REQ-020 IDLE: the accepted byte SHALL be the word count N; N=0 goes to RUN, N>0 goes to LOAD with word index 0.
REQ-021 LOAD: bytes SHALL be assembled big-endian, first byte into wdata[31:24]; after the 4th byte, go to WRITE.
REQ-022 WRITE (exactly one cycle): wr=1, addr=word index, wdata=assembled word; then index+1 and LOAD, or RUN if index=N-1.
REQ-023 wr SHALL be 0 in every state except WRITE; addr and wdata SHALL hold their last values outside WRITE.
REQ-024 RUN: working=1 for exactly RUN_CYCLES consecutive cycles, then DSEL with register index 0; working SHALL be 0 in all other states.
REQ-025 DSEL (one cycle): rID=register index; at the end of the cycle out_data SHALL capture rdata; then go to DOUT.
REQ-026 DOUT: out_valid=1, and out_data and rID SHALL be held stable until a rising edge with out_ready=1.
REQ-027 On acceptance in DOUT: if index<NUM_REGS-1, index+1 and DSEL; otherwise done=1 for one cycle, rID=4'hF, and IDLE.
REQ-028 rID SHALL be 4'hF in IDLE, LOAD, WRITE and RUN.
REQ-029 in_valid during WRITE, RUN, DSEL or DOUT SHALL be ignored, with no byte consumed.
REQ-030 Since N<=255, addr SHALL never exceed 254; the word index SHALL restart at 0 for each new program.

Reset
REQ-031 When reset is asserted, state SHALL go to IDLE immediately, from any state including mid-LOAD or mid-RUN.
REQ-032 Reset values: addr=0, wr=0, wdata=0, working=0, rID=4'hF, out_valid=0, out_data=0, done=0, byte/word/register counters=0.
REQ-033 A partially assembled word or unfinished run SHALL be discarded on reset; the next accepted byte is a new word count.

Verification
REQ-034 Bytes 01,10,F0,00,80 with in_valid held -> exactly one wr=1 cycle with addr=0 and wdata=0x10F00080, followed by working=1 for 28 cycles.
REQ-035 Load N=20, then words 0x10F00080 .. 0x22170000 -> 20 wr pulses at addr 0..19 in order with the matching wdata; rdata model returns 0x100+rID -> out_data sequence 0x100..0x107 with rID 0..7; done pulses once; rID returns to F.
REQ-036 Byte 00 -> no wr pulse; working=1 for 28 cycles; readback proceeds normally.
REQ-037 Hold out_ready=0 for 5 cycles at register 3 -> out_valid, out_data and rID=3 stay stable for those cycles; the sequence resumes when out_ready=1.
REQ-038 Assert reset after the 2nd byte of a word, and again mid-RUN -> all outputs take their reset values asynchronously; a fresh load after reset writes from addr=0.
REQ-039 Toggle in_valid randomly during LOAD and drive in_valid=1 during RUN -> wdata is assembled only from accepted bytes; no bytes are consumed during RUN.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: receives a word count and big-endian program words over a
// byte stream, writes them into the processor instruction memory, runs the
// processor for a fixed number of cycles, then streams out its registers.
//
// state | meaning
// IDLE  | wait for the word-count byte
// LOAD  | assemble four bytes of the current program word
// WRITE | one-cycle instruction memory write of the assembled word
// RUN   | processor enabled for RUN_CYCLES cycles
// DSEL  | select a register and capture its value
// DOUT  | present the captured register until the consumer accepts it
module prog_loader #(
    parameter int RUN_CYCLES = 28,
    parameter int NUM_REGS   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] addr,
    output logic        wr,
    output logic [31:0] wdata,
    output logic        working,
    output logic [3:0]  rID,
    input  logic [31:0] rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, DSEL, DOUT} state_t;

    // Run timer is a down-counter loaded with RUN_CYCLES-1; terminal count ends the run.
    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [RUN_W-1:0] RUN_LOAD = RUN_W'(RUN_CYCLES - 1);
    localparam logic [3:0] LAST_REG = 4'(NUM_REGS - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       widx_q, widx_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [3:0]       ridx_q, ridx_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             done_q, done_d;

    // State and datapath registers, all cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            widx_q     <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            run_q      <= '0;
            ridx_q     <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            widx_q     <= widx_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            run_q      <= run_d;
            ridx_q     <= ridx_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    // Next-state and datapath update; only IDLE and LOAD look at in_valid.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        widx_d     = widx_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        run_d      = run_q;
        ridx_d     = ridx_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d  = in_data;
                    widx_d = '0;
                    bcnt_d = '0;
                    if (in_data == 8'd0) begin
                        run_d   = RUN_LOAD;
                        state_d = RUN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    word_d = {word_q[23:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        addr_d  = {24'd0, widx_q};
                        wdata_d = {word_q[23:0], in_data};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (widx_q == cnt_q - 8'd1) begin
                    run_d   = RUN_LOAD;
                    state_d = RUN;
                end else begin
                    widx_d  = widx_q + 8'd1;
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (run_q == '0) begin
                    ridx_d  = '0;
                    state_d = DSEL;
                end else begin
                    run_d = run_q - 1'b1;
                end
            end
            DSEL: begin
                out_data_d = rdata;
                state_d    = DOUT;
            end
            DOUT: begin
                if (out_ready) begin
                    if (ridx_q == LAST_REG) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ridx_d  = ridx_q + 4'd1;
                        state_d = DSEL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; in_ready is also gated by reset itself.
    always_comb begin
        in_ready  = !reset && (state_q == IDLE || state_q == LOAD);
        wr        = (state_q == WRITE);
        working   = (state_q == RUN);
        out_valid = (state_q == DOUT);
        rID       = (state_q == DSEL || state_q == DOUT) ? ridx_q : 4'hF;
    end

    assign addr     = addr_q;
    assign wdata    = wdata_q;
    assign out_data = out_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized byte streams with gaps,
// aborts by reset, and a behavioural model compared every cycle.
module tb_prog_loader;
    localparam int RUN_CYCLES = 28;
    localparam int NUM_REGS   = 8;
    localparam int P_CNT = 0, P_BYTES = 1, P_WR = 2, P_RUN = 3, P_SEL = 4, P_OUT = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        working;
    logic [3:0]  rID;
    logic [31:0] rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Processor register file stand-in: register k holds 0x100+k.
    assign rdata = 32'h100 + {28'd0, rID};

    prog_loader #(.RUN_CYCLES(RUN_CYCLES), .NUM_REGS(NUM_REGS)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .addr(addr), .wr(wr), .wdata(wdata),
        .working(working), .rID(rID), .rdata(rdata), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .done(done)
    );

    // Program words the driver intends to send; consumed by the model in order.
    logic [31:0] prog[$];
    logic [31:0] exp_words[$];
    int          rd_ptr;

    // Observations gathered by the compare process for the directed pins.
    logic [31:0] obs_wa[$];
    logic [31:0] obs_wd[$];
    logic [31:0] obs_out[$];
    int obs_work = 0, obs_done = 0, obs_ov3 = 0;

    bit hold_req = 1'b0;
    int holds_done = 0;

    int m_ph, m_n, m_wi, m_nb, m_rc, m_ri;
    logic [31:0] m_addr, m_wdata, m_outd;
    logic m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Compare process: every falling edge compare DUT outputs with the model,
    // then advance the model by what the coming rising edge will see.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("rst_in_ready", 32'(in_ready), 32'd0);
                chk("rst_addr", addr, 32'd0);
                chk("rst_wr", 32'(wr), 32'd0);
                chk("rst_wdata", wdata, 32'd0);
                chk("rst_working", 32'(working), 32'd0);
                chk("rst_rID", 32'(rID), 32'hF);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_data", out_data, 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                m_ph = P_CNT; m_n = 0; m_wi = 0; m_nb = 0; m_rc = 0; m_ri = 0;
                m_addr = '0; m_wdata = '0; m_outd = '0; m_done = 1'b0;
                rd_ptr = exp_words.size();
            end else begin
                chk("in_ready", 32'(in_ready), 32'(m_ph == P_CNT || m_ph == P_BYTES));
                chk("wr", 32'(wr), 32'(m_ph == P_WR));
                chk("addr", addr, m_addr);
                chk("wdata", wdata, m_wdata);
                chk("working", 32'(working), 32'(m_ph == P_RUN));
                chk("rID", 32'(rID), (m_ph == P_SEL || m_ph == P_OUT) ? 32'(m_ri) : 32'hF);
                chk("out_valid", 32'(out_valid), 32'(m_ph == P_OUT));
                chk("out_data", out_data, m_outd);
                chk("done", 32'(done), 32'(m_done));

                if (wr) begin obs_wa.push_back(addr); obs_wd.push_back(wdata); end
                if (working) obs_work++;
                if (done) obs_done++;
                if (out_valid && rID == 4'd3) obs_ov3++;
                if (out_valid && out_ready) obs_out.push_back(out_data);

                m_done = 1'b0;
                case (m_ph)
                    P_CNT: if (in_valid) begin
                        m_n = int'(in_data);
                        if (m_n == 0) begin m_ph = P_RUN; m_rc = 0; end
                        else begin m_ph = P_BYTES; m_wi = 0; m_nb = 0; end
                    end
                    P_BYTES: if (in_valid) begin
                        m_nb++;
                        if (m_nb == 4) begin
                            m_ph = P_WR;
                            m_addr = 32'(m_wi);
                            if (rd_ptr < exp_words.size()) begin
                                m_wdata = exp_words[rd_ptr];
                                rd_ptr++;
                            end else begin
                                checks++; errors++;
                                $display("FAIL wr_source: got no program word expected one at %0t", $time);
                            end
                        end
                    end
                    P_WR: if (m_wi == m_n - 1) begin m_ph = P_RUN; m_rc = 0; end
                          else begin m_wi++; m_nb = 0; m_ph = P_BYTES; end
                    P_RUN: begin
                        m_rc++;
                        if (m_rc == RUN_CYCLES) begin m_ph = P_SEL; m_ri = 0; end
                    end
                    P_SEL: begin m_outd = 32'h100 + 32'(m_ri); m_ph = P_OUT; end
                    P_OUT: if (out_ready) begin
                        if (m_ri == NUM_REGS - 1) begin m_done = 1'b1; m_ph = P_CNT; end
                        else begin m_ri++; m_ph = P_SEL; end
                    end
                    default: m_ph = P_CNT;
                endcase
            end
        end
    end

    // Consumer: random out_ready, with one directed 5-cycle stall at register 3.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (hold_req && holds_done == 0 && out_valid && rID == 4'd3) begin
                repeat (5) begin
                    out_ready = 1'b0;
                    @(posedge clock); #1;
                end
                holds_done++;
                out_ready = 1'b1;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic apply_reset();
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_working", 32'(working), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        chk("async_rID", 32'(rID), 32'hF);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 1'b0;
        int guard = 0;
        while (!acc) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
            end
            @(negedge clock);
            acc = in_valid && in_ready;
            @(posedge clock); #1;
            guard++;
            if (guard > 1000) timeout_fail("send_byte");
        end
    endtask

    // Sends the count and all words of prog; abort_after>0 resets after that many accepted bytes.
    task automatic send_program(input bit gaps, input int abort_after);
        logic [7:0]  bytes_q[$];
        logic [31:0] w;
        bytes_q.push_back(8'(prog.size()));
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            exp_words.push_back(w);
            bytes_q.push_back(w[31:24]);
            bytes_q.push_back(w[23:16]);
            bytes_q.push_back(w[15:8]);
            bytes_q.push_back(w[7:0]);
        end
        for (int i = 0; i < bytes_q.size(); i++) begin
            send_byte(bytes_q[i], gaps);
            if (i + 1 == abort_after) begin
                apply_reset();
                return;
            end
        end
    endtask

    // Keeps in_valid high with junk (must be ignored) until done pulses.
    task automatic run_to_done();
        int guard = 0;
        while (!done) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clock); #1;
            guard++;
            if (guard > 3000) timeout_fail("run_to_done");
        end
        in_valid = 1'b0;
    endtask

    int wa0, work0, done0, out0, ov30, guard;

    task automatic snap();
        wa0 = obs_wa.size(); work0 = obs_work; done0 = obs_done;
        out0 = obs_out.size(); ov30 = obs_ov3;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0;
        @(negedge clock); @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;

        // Single word 0x10F00080, no gaps.
        snap();
        prog = '{32'h10F00080};
        send_program(1'b0, -1);
        run_to_done();
        chk("single_wr_count", 32'(obs_wa.size() - wa0), 32'd1);
        chk("single_addr", obs_wa[wa0], 32'd0);
        chk("single_wdata", obs_wd[wa0], 32'h10F00080);
        chk("single_work_cycles", 32'(obs_work - work0), 32'd28);

        // Twenty words, full readback.
        snap();
        prog.delete();
        prog.push_back(32'h10F00080);
        for (int i = 1; i < 19; i++) prog.push_back($urandom);
        prog.push_back(32'h22170000);
        send_program(1'b0, -1);
        run_to_done();
        chk("p20_wr_count", 32'(obs_wa.size() - wa0), 32'd20);
        chk("p20_first_addr", obs_wa[wa0], 32'd0);
        chk("p20_last_addr", obs_wa[wa0 + 19], 32'd19);
        chk("p20_last_wdata", obs_wd[wa0 + 19], 32'h22170000);
        chk("p20_out_count", 32'(obs_out.size() - out0), 32'd8);
        chk("p20_out_first", obs_out[out0], 32'h100);
        chk("p20_out_last", obs_out[out0 + 7], 32'h107);
        chk("p20_done_count", 32'(obs_done - done0), 32'd1);
        chk("p20_rID_idle", 32'(rID), 32'hF);

        // Empty program.
        snap();
        prog.delete();
        send_program(1'b0, -1);
        run_to_done();
        chk("n0_wr_count", 32'(obs_wa.size() - wa0), 32'd0);
        chk("n0_work_cycles", 32'(obs_work - work0), 32'd28);
        chk("n0_out_count", 32'(obs_out.size() - out0), 32'd8);

        // Consumer stall at register 3.
        snap();
        hold_req = 1'b1;
        prog = '{32'hA5A55A5A};
        send_program(1'b1, -1);
        run_to_done();
        chk("stall_holds", 32'(holds_done), 32'd1);
        chk("stall_ov3_cycles", 32'(obs_ov3 - ov30), 32'd6);
        chk("stall_reg3", obs_out[out0 + 3], 32'h103);

        // Reset after the second byte of the first word, then a fresh load.
        prog = '{32'hDEADBEEF, 32'h01234567};
        send_program(1'b0, 3);
        snap();
        prog = '{32'hCAFEF00D, 32'h0BADC0DE};
        send_program(1'b1, -1);
        run_to_done();
        chk("abort_load_first_addr", obs_wa[wa0], 32'd0);
        chk("abort_load_first_wdata", obs_wd[wa0], 32'hCAFEF00D);
        chk("abort_load_wr_count", 32'(obs_wa.size() - wa0), 32'd2);

        // Reset in the middle of a run, then a fresh load.
        prog = '{32'h11111111, 32'h22222222, 32'h33333333};
        send_program(1'b0, -1);
        guard = 0;
        while (!working) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            @(posedge clock); #1;
            guard++;
            if (guard > 100) timeout_fail("wait_working");
        end
        repeat (10) begin in_valid = 1'b1; in_data = 8'($urandom); @(posedge clock); #1; end
        apply_reset();
        snap();
        prog = '{32'h44556677};
        send_program(1'b0, -1);
        run_to_done();
        chk("abort_run_addr", obs_wa[wa0], 32'd0);
        chk("abort_run_wdata", obs_wd[wa0], 32'h44556677);
        chk("abort_run_work_cycles", 32'(obs_work - work0), 32'd28);

        // Random programs with random byte gaps.
        for (int k = 0; k < 8; k++) begin
            prog.delete();
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) prog.push_back($urandom);
            send_program(1'b1, -1);
            run_to_done();
        end

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
